// File: rtl/mac_layer_sequencer.sv
// Multi-lane fully-connected layer sequencer: walks a layer-size program, streams neurons and
// packed weights, accumulates LANES outputs in parallel and writes them to a ping-pong buffer.
module mac_layer_sequencer #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int LANES     = 4,
  parameter int SHIFT     = 0,
  parameter int NADDR_W   = 10,
  parameter int WADDR_W   = 13,
  parameter int IADDR_W   = 8,
  parameter int IDATA_W   = 16,
  parameter int BASE_LOW  = 0,
  parameter int BASE_HIGH = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     relu_en,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [IADDR_W-1:0]       instr_addr,
  input  logic [IDATA_W-1:0]       instr_data,
  output logic [NADDR_W-1:0]       n_rd_addr,
  input  logic [DATA_W-1:0]        n_rd_data,
  output logic [WADDR_W-1:0]       w_rd_addr,
  input  logic [LANES*DATA_W-1:0]  w_rd_data,
  output logic                     n_wr_en,
  output logic [NADDR_W-1:0]       n_wr_addr,
  output logic [DATA_W-1:0]        n_wr_data,
  output logic [NADDR_W-1:0]       result_base,
  output logic [IDATA_W-1:0]       result_count
);

  localparam logic [IDATA_W-1:0] END_WORD = {IDATA_W{1'b1}};
  localparam logic [IDATA_W-1:0] ZERO_WORD = {IDATA_W{1'b0}};
  localparam logic [IDATA_W-1:0] LANES_W = IDATA_W'(LANES);
  localparam logic [NADDR_W-1:0] LOW_A = NADDR_W'(BASE_LOW);
  localparam logic [NADDR_W-1:0] HIGH_A = NADDR_W'(BASE_HIGH);
  localparam logic [IADDR_W-1:0] IP_ONE = IADDR_W'(1);
  localparam logic [IADDR_W-1:0] IP_TWO = IADDR_W'(2);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(2 ** (DATA_W - 1)));

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH0, S_FETCH, S_CLEAR, S_STREAM, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t                    state_r;
  logic                      relu_r;
  logic                      buf_sel_r;
  logic                      pend_r;
  logic [IADDR_W-1:0]        ip_r;
  logic [IDATA_W-1:0]        prev_r;
  logic [IDATA_W-1:0]        cur_r;
  logic [IDATA_W-1:0]        out_idx_r;
  logic [IDATA_W-1:0]        in_idx_r;
  logic [IDATA_W-1:0]        lane_r;
  logic signed [ACC_W-1:0]   acc_r [LANES];

  logic [NADDR_W-1:0]        src_s;
  logic [NADDR_W-1:0]        dst_s;
  logic [IDATA_W-1:0]        rem_s;
  logic [IDATA_W-1:0]        active_s;
  logic [IDATA_W-1:0]        wr_idx_s;
  logic signed [2*DATA_W-1:0] prod_s [LANES];
  logic signed [ACC_W-1:0]   acc_nxt_s [LANES];
  logic signed [ACC_W-1:0]   wr_acc_s;

  // Shift, saturate to the neuron range, then optionally clip negatives.
  function automatic logic [DATA_W-1:0] act_f(input logic signed [ACC_W-1:0] x, input logic relu);
    logic signed [ACC_W-1:0] y;
    y = x >>> SHIFT;
    y = (y > SAT_MAX) ? SAT_MAX : ((y < SAT_MIN) ? SAT_MIN : y);
    y = (relu && y[ACC_W-1]) ? '0 : y;
    return y[DATA_W-1:0];
  endfunction

  // Buffer selection, group size, lane products and the lane value feeding the write port.
  always_comb begin
    src_s    = buf_sel_r ? HIGH_A : LOW_A;
    dst_s    = buf_sel_r ? LOW_A : HIGH_A;
    rem_s    = cur_r - out_idx_r;
    active_s = (rem_s < LANES_W) ? rem_s : LANES_W;
    wr_idx_s = (state_r == S_DRAIN) ? ZERO_WORD : lane_r + 1'b1;
    for (int l = 0; l < LANES; l++) begin
      prod_s[l] = $signed(n_rd_data) * $signed(w_rd_data[l*DATA_W +: DATA_W]);
      if (pend_r) begin
        acc_nxt_s[l] = acc_r[l] + ACC_W'(prod_s[l]);
      end else begin
        acc_nxt_s[l] = acc_r[l];
      end
    end
    wr_acc_s = acc_nxt_s[0];
    for (int l = 1; l < LANES; l++) begin
      wr_acc_s = (wr_idx_s == IDATA_W'(l)) ? acc_nxt_s[l] : wr_acc_s;
    end
  end

  // Sequencer FSM with all datapath state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      relu_r       <= 1'b0;
      buf_sel_r    <= 1'b0;
      pend_r       <= 1'b0;
      ip_r         <= '0;
      prev_r       <= '0;
      cur_r        <= '0;
      out_idx_r    <= '0;
      in_idx_r     <= '0;
      lane_r       <= '0;
      for (int l = 0; l < LANES; l++) acc_r[l] <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      instr_addr   <= '0;
      n_rd_addr    <= '0;
      w_rd_addr    <= '0;
      n_wr_en      <= 1'b0;
      n_wr_addr    <= '0;
      n_wr_data    <= '0;
      result_base  <= LOW_A;
      result_count <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            err        <= 1'b0;
            relu_r     <= relu_en;
            ip_r       <= '0;
            instr_addr <= '0;
            w_rd_addr  <= '0;
            buf_sel_r  <= 1'b0;
            state_r    <= S_FETCH0;
          end
        end
        S_FETCH0: begin
          if (instr_data == END_WORD) begin
            result_base  <= LOW_A;
            result_count <= '0;
            busy         <= 1'b0;
            done         <= 1'b1;
            state_r      <= S_DONE;
          end else if (instr_data == ZERO_WORD) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= S_DONE;
          end else begin
            prev_r     <= instr_data;
            instr_addr <= ip_r + IP_ONE;
            state_r    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (instr_data == END_WORD) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= S_DONE;
          end else if (instr_data == ZERO_WORD) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= S_DONE;
          end else begin
            cur_r     <= instr_data;
            out_idx_r <= '0;
            state_r   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          for (int l = 0; l < LANES; l++) acc_r[l] <= '0;
          in_idx_r  <= '0;
          pend_r    <= 1'b0;
          n_rd_addr <= src_s;
          state_r   <= S_STREAM;
        end
        S_STREAM: begin
          // Data requested last cycle lands now; this cycle's request lands next cycle.
          for (int l = 0; l < LANES; l++) acc_r[l] <= acc_nxt_s[l];
          pend_r    <= 1'b1;
          in_idx_r  <= in_idx_r + 1'b1;
          w_rd_addr <= w_rd_addr + 1'b1;
          n_rd_addr <= src_s + NADDR_W'(in_idx_r + 1'b1);
          if ((in_idx_r + 1'b1) == prev_r) begin
            state_r <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          for (int l = 0; l < LANES; l++) acc_r[l] <= acc_nxt_s[l];
          pend_r    <= 1'b0;
          lane_r    <= '0;
          n_wr_en   <= 1'b1;
          n_wr_addr <= dst_s + NADDR_W'(out_idx_r);
          n_wr_data <= act_f(wr_acc_s, relu_r);
          state_r   <= S_WRITE;
        end
        S_WRITE: begin
          if ((lane_r + 1'b1) < active_s) begin
            lane_r    <= lane_r + 1'b1;
            n_wr_addr <= dst_s + NADDR_W'(out_idx_r + lane_r + 1'b1);
            n_wr_data <= act_f(wr_acc_s, relu_r);
          end else begin
            n_wr_en   <= 1'b0;
            out_idx_r <= out_idx_r + active_s;
            if ((out_idx_r + active_s) < cur_r) begin
              state_r <= S_CLEAR;
            end else begin
              result_base  <= dst_s;
              result_count <= cur_r;
              prev_r       <= cur_r;
              ip_r         <= ip_r + IP_ONE;
              instr_addr   <= ip_r + IP_TWO;
              buf_sel_r    <= ~buf_sel_r;
              state_r      <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Directed bench for mac_layer_sequencer with behavioural instruction ROM, weight ROM and neuron RAM.
module tb_mac_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        relu_en = 1'b0;
  logic        busy, done, err;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data;
  logic [9:0]  n_rd_addr;
  logic [7:0]  n_rd_data;
  logic [12:0] w_rd_addr;
  logic [31:0] w_rd_data;
  logic        n_wr_en;
  logic [9:0]  n_wr_addr;
  logic [7:0]  n_wr_data;
  logic [9:0]  result_base;
  logic [15:0] result_count;

  logic [15:0] prog [0:255];
  logic [31:0] wrom [0:8191];
  logic [7:0]  nram [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = 10'd0;
  logic [7:0]  pl_data = 8'd0;
  logic [9:0]  log_addr [0:63];
  logic [7:0]  log_data [0:63];
  int          wr_cnt = 0;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp3 [0:5] = '{8'h06, 8'h0C, 8'h12, 8'h18, 8'hFA, 8'hF4};
  logic [9:0]  exp4_a [0:4] = '{10'd512, 10'd513, 10'd514, 10'd0, 10'd1};
  logic [7:0]  exp4_d [0:4] = '{8'h03, 8'h00, 8'h06, 8'h0F, 8'hF1};

  mac_layer_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .busy(busy), .done(done), .err(err),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .n_rd_addr(n_rd_addr), .n_rd_data(n_rd_data),
    .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .n_wr_en(n_wr_en), .n_wr_addr(n_wr_addr), .n_wr_data(n_wr_data),
    .result_base(result_base), .result_count(result_count)
  );

  always #5 clk = ~clk;

  assign instr_data = prog[instr_addr];

  // Synchronous-read memories plus a log of every neuron write.
  always @(posedge clk) begin
    n_rd_data <= nram[n_rd_addr];
    w_rd_data <= wrom[w_rd_addr];
    if (pl_en) nram[pl_addr] <= pl_data;
    else if (n_wr_en) nram[n_wr_addr] <= n_wr_data;
    if (n_wr_en) begin
      log_addr[wr_cnt % 64] <= n_wr_addr;
      log_data[wr_cnt % 64] <= n_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input logic [7:0] val);
    pl_en = 1'b1;
    pl_addr = 10'(addr);
    pl_data = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Pulse start, count edges until done, then settle one cycle back into idle.
  task automatic run(input logic relu, output int lat);
    relu_en = relu;
    start = 1'b1;
    lat = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (done) break;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int base;
    for (int i = 0; i < 256; i++) prog[i] = 16'hFFFF;
    for (int i = 0; i < 8192; i++) wrom[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_wr_en", {31'd0, n_wr_en}, 32'd0);
    check("rst_iaddr", instr_addr, 32'd0);
    check("rst_waddr", w_rd_addr, 32'd0);
    check("rst_rbase", result_base, 32'd0);
    check("rst_rcount", result_count, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic single neuron: 3*2 + 4*5 = 26
    prog[0] = 16'd2; prog[1] = 16'd1; prog[2] = 16'hFFFF;
    wrom[0] = 32'h0907_0102;
    wrom[1] = 32'h0B0A_0605;
    load(0, 8'd3);
    load(1, 8'd4);
    base = wr_cnt;
    run(1'b0, lat);
    check("t1_latency", lat, 32'd9);
    check("t1_nwrites", wr_cnt - base, 32'd1);
    check("t1_addr", log_addr[base % 64], 32'd512);
    check("t1_data", log_data[base % 64], 32'd26);
    check("t1_rbase", result_base, 32'd512);
    check("t1_rcount", result_count, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_wr_idle", {31'd0, n_wr_en}, 32'd0);

    // Reset asserted during STREAM
    relu_en = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t6_busy", {31'd0, busy}, 32'd1);
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("t6_busy_rst", {31'd0, busy}, 32'd0);
    check("t6_done_rst", {31'd0, done}, 32'd0);
    check("t6_wr_en_rst", {31'd0, n_wr_en}, 32'd0);
    check("t6_iaddr_rst", instr_addr, 32'd0);
    check("t6_waddr_rst", w_rd_addr, 32'd0);
    check("t6_naddr_rst", n_rd_addr, 32'd0);
    check("t6_rbase_rst", result_base, 32'd0);
    check("t6_rcount_rst", result_count, 32'd0);
    base = wr_cnt;
    repeat (3) @(posedge clk); #1;
    check("t6_wr_en_hold", {31'd0, n_wr_en}, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("t6_no_writes", wr_cnt - base, 32'd0);
    base = wr_cnt;
    run(1'b0, lat);
    check("t6_latency", lat, 32'd9);
    check("t6_nwrites", wr_cnt - base, 32'd1);
    check("t6_addr", log_addr[base % 64], 32'd512);
    check("t6_data", log_data[base % 64], 32'd26);
    check("t6_rbase", result_base, 32'd512);

    // Saturation with and without ReLU
    do_reset();
    prog[0] = 16'd2; prog[1] = 16'd2; prog[2] = 16'hFFFF;
    wrom[0] = 32'h0000_807F;
    wrom[1] = 32'h0000_807F;
    load(0, 8'd127);
    load(1, 8'd127);
    base = wr_cnt;
    run(1'b0, lat);
    check("t2_nwrites", wr_cnt - base, 32'd2);
    check("t2_pos_sat", log_data[base % 64], 32'h7F);
    check("t2_neg_sat", log_data[(base + 1) % 64], 32'h80);
    do_reset();
    base = wr_cnt;
    run(1'b1, lat);
    check("t2r_pos_sat", log_data[base % 64], 32'h7F);
    check("t2r_relu", log_data[(base + 1) % 64], 32'h00);

    // Partial second group: 3 inputs, 6 outputs
    do_reset();
    prog[0] = 16'd3; prog[1] = 16'd6; prog[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) wrom[i] = 32'h0403_0201;
    for (int i = 3; i < 6; i++) wrom[i] = 32'h0101_FEFF;
    load(0, 8'd1);
    load(1, 8'd2);
    load(2, 8'd3);
    base = wr_cnt;
    run(1'b0, lat);
    check("t3_latency", lat, 32'd20);
    check("t3_nwrites", wr_cnt - base, 32'd6);
    for (int k = 0; k < 6; k++) begin
      check("t3_addr", log_addr[(base + k) % 64], 32'd512 + 32'(k));
      check("t3_data", log_data[(base + k) % 64], {24'd0, exp3[k]});
    end
    check("t3_wptr", w_rd_addr, 32'd6);
    check("t3_rcount", result_count, 32'd6);

    // Two layers, second reads the pong buffer and writes the ping buffer
    do_reset();
    prog[0] = 16'd2; prog[1] = 16'd3; prog[2] = 16'd2; prog[3] = 16'hFFFF;
    wrom[0] = 32'h0000_0201;
    wrom[1] = 32'h0003_FF01;
    wrom[2] = 32'h0000_FF01;
    wrom[3] = 32'h0000_0705;
    wrom[4] = 32'h0000_FE02;
    load(0, 8'd1);
    load(1, 8'd2);
    base = wr_cnt;
    run(1'b0, lat);
    check("t4_nwrites", wr_cnt - base, 32'd5);
    for (int k = 0; k < 5; k++) begin
      check("t4_addr", log_addr[(base + k) % 64], {22'd0, exp4_a[k]});
      check("t4_data", log_data[(base + k) % 64], {24'd0, exp4_d[k]});
    end
    check("t4_rbase", result_base, 32'd0);
    check("t4_rcount", result_count, 32'd2);
    check("t4_wptr", w_rd_addr, 32'd5);

    // Zero layer size, then an empty program clears the sticky error
    do_reset();
    prog[0] = 16'd2; prog[1] = 16'd0; prog[2] = 16'hFFFF;
    base = wr_cnt;
    run(1'b0, lat);
    check("t5z_latency", lat, 32'd3);
    check("t5z_err", {31'd0, err}, 32'd1);
    check("t5z_nwrites", wr_cnt - base, 32'd0);
    repeat (2) @(posedge clk); #1;
    check("t5z_err_sticky", {31'd0, err}, 32'd1);
    prog[0] = 16'hFFFF;
    base = wr_cnt;
    run(1'b0, lat);
    check("t5e_latency", lat, 32'd2);
    check("t5e_err", {31'd0, err}, 32'd0);
    check("t5e_nwrites", wr_cnt - base, 32'd0);
    check("t5e_rbase", result_base, 32'd0);
    check("t5e_rcount", result_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_layer_sequencer.md
# mac_layer_sequencer

Multi-lane, start/done-driven layer sequencer for the fully-connected inference datapath. It walks a layer-size program, streams input neurons and packed weights from external memories, and accumulates LANES output neurons in parallel. It writes saturated, optionally ReLU-clipped results back to a ping-pong neuron buffer. It sits between the instruction ROM, weight ROM and neuron dual-port RAM, and replaces the single-MAC, reset-started control path.

## Interface
- DATA_W, 8, signed neuron/weight width
- ACC_W, 24, signed accumulator width
- LANES, 4, parallel output neurons per group (≥1)
- SHIFT, 0, arithmetic right shift applied before saturation
- NADDR_W, 10, neuron RAM address width
- WADDR_W, 13, weight ROM address width
- IADDR_W, 8, instruction address width
- IDATA_W, 16, instruction word width
- BASE_LOW, 0, ping buffer base; BASE_HIGH, 512, pong buffer base
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  run request, sampled only in IDLE
- relu_en  in  1  ReLU mode, latched on accepted start
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse in DONE
- err  out  1  sticky until next accepted start; zero layer size
- instr_addr  out  IADDR_W  instruction ROM address (combinational-read ROM)
- instr_data  in  IDATA_W  layer size at instr_addr
- n_rd_addr  out  NADDR_W  neuron read address (data valid next cycle)
- n_rd_data  in  DATA_W  neuron read data
- w_rd_addr  out  WADDR_W  weight word address (data valid next cycle)
- w_rd_data  in  LANES*DATA_W  packed weights, lane l at [l*DATA_W +: DATA_W]
- n_wr_en, n_wr_addr (NADDR_W), n_wr_data (DATA_W)  out  neuron write port
- result_base  out  NADDR_W  base address of the last completed layer
- result_count  out  IDATA_W  size of the last completed layer

## Operation
- Program layout: word 0 = N0, the input size, preloaded at BASE_LOW. Word k = Nk. All-ones = END.
- FSM: IDLE→FETCH0→FETCH→CLEAR→STREAM→DRAIN→WRITE→(CLEAR | FETCH)→…→DONE→IDLE.
- FETCH0: reads ip=0 into prev. END→DONE, with result_base=BASE_LOW and result_count=0. Zero→err, DONE.
- FETCH: reads ip+1 into cur. END→DONE. Zero→err, DONE. Otherwise start the layer with out_idx=0.
- Layer k reads from src = BASE_LOW for odd k and BASE_HIGH for even k. It writes to dst, the other buffer.
- CLEAR: zero all LANES accumulators; in_idx=0.
- STREAM: prev cycles. Each cycle issues n_rd_addr=src+in_idx and w_rd_addr=wptr, then increments in_idx and wptr. Returned data accumulates one cycle later: acc[l] += n_rd_data * w[l], as a signed full product, wrapping in ACC_W.
- DRAIN: absorbs the last returned data.
- WRITE: active = min(LANES, cur-out_idx) cycles. Lane l writes n_wr_addr=dst+out_idx+l and n_wr_data=act(acc[l]). Lanes are written in ascending order. Inactive lanes never write, but their weights still occupy the word.
- act(x): y = x >>> SHIFT, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. If relu_en, y<0 → 0.
- After WRITE: out_idx += active. If out_idx<cur → CLEAR. Otherwise update result_base=dst and result_count=cur, set prev=cur, ip+=1, swap buffers → FETCH.
- wptr is never reset between layers; the weight stream is contiguous across the whole program.
- start while busy is ignored.

## Timing
- Reset values: busy=0, done=0, err=0, n_wr_en=0, all addresses 0, result_base=BASE_LOW, result_count=0, state IDLE, ip=0, wptr=0.
- Cycles per group = 1 + prev + 1 + active. Each FETCH/FETCH0 costs 1 cycle; DONE costs 1 cycle.
- Write-port outputs are registered and change only in WRITE.
- Reset mid-run aborts immediately. No further n_wr_en is raised, and the next start runs from ip=0, wptr=0.
- done and a new start in the same cycle: the start is ignored. It is accepted in IDLE the next cycle.

## Test plan
- LANES=4, SHIFT=0, program {2,1,END}, inputs {3,4}, lane0 weights {2,5} → one write of 26 at BASE_HIGH. done pulses 1+1+1+(1+2+1+1)+1 cycles after start. result_base=BASE_HIGH, result_count=1.
- Saturation: N0=2, inputs {127,127}, weights {127,127} → 127. Weights {-128,-128} → -128 with relu_en=0, and 0 with relu_en=1.
- Partial group: N0=3, N1=6, LANES=4 → two groups with exactly 6 writes at BASE_HIGH+0..5 in order. wptr ends at 6.
- Two layers {2,3,2,END} → layer-2 reads from BASE_HIGH and writes to BASE_LOW. result_base=BASE_LOW, result_count=2. Values match a software model.
- Program {END} → done two cycles after start, no writes, err=0. Program {2,0,END} → done with err=1 and no writes.
- reset low during STREAM → all outputs are at reset values while reset is low. A subsequent start reproduces the first test's result exactly.
